imm_gen: RTL and testbench

RV32I immediate generator. It decodes the instruction format from opcode bits [6:0], extracts the scattered immediate fields, reassembles them and sign-extends the result. The result is registered, one cycle after the instruction is presented. It sits in the fetch/decode stage and feeds the ALU operand mux, branch/jump target adder and load/store address path.

---
 rtl/imm_gen_pkg.sv | 41 ++++
 rtl/imm_gen_if.sv | 37 +++
 rtl/imm_gen_decode.sv | 32 +++
 rtl/imm_gen.sv | 63 ++++++
 tb/tb_imm_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, instruction-format enum and opcode classifier for the
// RV32I immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  // R-type and any unrecognised opcode (including instr[1:0] != 2'b11) yield FMT_NONE.
  function automatic fmt_e opc_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: f = FMT_I;
      OPC_STORE:            f = FMT_S;
      OPC_BRANCH:           f = FMT_B;
      OPC_LUI, OPC_AUIPC:   f = FMT_U;
      OPC_JAL:              f = FMT_J;
      OPC_OP:               f = FMT_NONE;
      default:              f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen_if.sv
// Bus between the decode-stage driver and the immediate generator.
// Optional fmt signal present when IMMGEN_FMT_OUT_EN is defined.
interface imm_gen_if #(
  parameter int XLEN = 32
);

  // Handshake: en is a one-cycle capture strobe with no ready/backpressure; every
  // rising clk with en=1 takes instr, and imm_valid pulses exactly one cycle later.
  logic            en;
  logic [31:0]     instr;
  logic [XLEN-1:0] imm;
  logic            imm_valid;
`ifdef IMMGEN_FMT_OUT_EN
  logic [2:0]      fmt;
`endif

  modport master (
    output en,
    output instr,
    input  imm,
`ifdef IMMGEN_FMT_OUT_EN
    input  fmt,
`endif
    input  imm_valid
  );

  modport slave (
    input  en,
    input  instr,
    output imm,
`ifdef IMMGEN_FMT_OUT_EN
    output fmt,
`endif
    output imm_valid
  );

endinterface

// File: rtl/imm_gen_decode.sv
// Combinational RV32I immediate decode: instr -> {fmt, sign-extended imm}.
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    fmt   = opc_fmt(instr[6:0]);
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Sign bit is always instr[31], so a signed widening covers U-type at XLEN=64 too.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen.sv
// RV32I immediate generator: combinational decode followed by one output register.
// Define IMMGEN_FMT_OUT_EN to also register and expose the decoded format.
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  imm_gen_if.slave bus
);

  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0] imm_d, imm_q;
  logic            valid_d, valid_q;

  imm_gen_decode #(.XLEN(XLEN)) u_decode (
    .instr (bus.instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  always_comb begin
    imm_d   = imm_q;
    valid_d = bus.en;
    if (bus.en) imm_d = dec_imm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imm       = imm_q;
  assign bus.imm_valid = valid_q;

`ifdef IMMGEN_FMT_OUT_EN
  fmt_e fmt_d, fmt_q;

  always_comb begin
    fmt_d = fmt_q;
    if (bus.en) fmt_d = dec_fmt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fmt_q <= FMT_NONE;
    else     fmt_q <= fmt_d;
  end

  assign bus.fmt = fmt_q;
`else
  fmt_e fmt_unused;
  assign fmt_unused = dec_fmt;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed vectors plus a randomized stream
// compared against an arithmetic reference model.
module tb_imm_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] exp_q[$];
  logic [2:0]  expf_q[$];

  imm_gen_if #(.XLEN(32)) bus();

  imm_gen #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: immediate value as a signed integer built from weighted fields.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    longint v;
    longint s;
    s = w[31] ? 64'sd1 : 64'sd0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73:
        v = longint'(w[31:20]) - s * 4096;
      7'h23:
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - s * 4096;
      7'h63:
        v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
          + longint'(w[11:8]) * 2 - s * 4096;
      7'h37, 7'h17:
        v = longint'(w[31:12]) * 4096 - s * (longint'(1) << 32);
      7'h6F:
        v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
          + longint'(w[30:21]) * 2 - s * (longint'(1) << 20);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [2:0] ref_fmt(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 3'd1;
      7'h23:        return 3'd2;
      7'h63:        return 3'd3;
      7'h37, 7'h17: return 3'd4;
      7'h6F:        return 3'd5;
      default:      return 3'd0;
    endcase
  endfunction

  // Drive one capture, wait for the edge, then sample 1 time unit later.
  task automatic drive_cycle(input logic e, input logic [31:0] w);
    bus.en    = e;
    bus.instr = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en    = 1'b1;
    bus.instr = 32'hFFF00093;
    rst       = 1'b1;
    #1;
    total++;
    if (bus.imm !== 32'h0 || bus.imm_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold imm=%h valid=%b want imm=0 valid=0", bus.imm, bus.imm_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.imm !== 32'h0 || bus.imm_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_edge imm=%h valid=%b want imm=0 valid=0", bus.imm, bus.imm_valid);
    end
    rst = 1'b0;
    drive_cycle(1'b1, 32'hFFF00093);
    total++;
    if (bus.imm !== 32'hFFFFFFFF || bus.imm_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_first imm=%h valid=%b want imm=ffffffff valid=1", bus.imm, bus.imm_valid);
    end
    // Asynchronous assertion between edges must clear outputs immediately.
    rst = 1'b1;
    #1;
    total++;
    if (bus.imm !== 32'h0 || bus.imm_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async imm=%h valid=%b want imm=0 valid=0", bus.imm, bus.imm_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.imm !== 32'h0 || bus.imm_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release imm=%h valid=%b want imm=0 valid=0", bus.imm, bus.imm_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vec_in [6];
    logic [31:0] vec_exp[6];
    vec_in[0] = 32'hFFF00093; vec_exp[0] = 32'hFFFFFFFF;
    vec_in[1] = 32'h0020A423; vec_exp[1] = 32'h00000008;
    vec_in[2] = 32'hFE000EE3; vec_exp[2] = 32'hFFFFFFFC;
    vec_in[3] = 32'h0010006F; vec_exp[3] = 32'h00000800;
    vec_in[4] = 32'h123450B7; vec_exp[4] = 32'h12345000;
    vec_in[5] = 32'h002081B3; vec_exp[5] = 32'h00000000;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, vec_in[i]);
      total++;
      if (bus.imm !== vec_exp[i] || bus.imm_valid !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d instr=%h imm=%h valid=%b want imm=%h valid=1",
                 i, vec_in[i], bus.imm, bus.imm_valid, vec_exp[i]);
      end
`ifdef IMMGEN_FMT_OUT_EN
      total++;
      if (bus.fmt !== ref_fmt(vec_in[i])) begin
        bad++;
        $display("FAIL directed_fmt_%0d fmt=%0d want %0d", i, bus.fmt, ref_fmt(vec_in[i]));
      end
`endif
    end
  endtask

  task automatic test_hold();
    drive_cycle(1'b1, 32'h123450B7);
    total++;
    if (bus.imm !== 32'h12345000 || bus.imm_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_capture imm=%h valid=%b want imm=12345000 valid=1", bus.imm, bus.imm_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 32'hFFF00093);
      total++;
      if (bus.imm !== 32'h12345000 || bus.imm_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_idle_%0d imm=%h valid=%b want imm=12345000 valid=0",
                 i, bus.imm, bus.imm_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] opcs[11];
    logic [31:0] w;
    logic [31:0] e;
    opcs = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    for (int i = 0; i < 27; i++) begin
      w = {$urandom()} & 32'hFFFFFF80;
      w[6:0] = opcs[$urandom_range(0, 10)];
      exp_q.push_back(ref_imm(w));
      expf_q.push_back(ref_fmt(w));
      drive_cycle(1'b1, w);
      e = exp_q.pop_front();
      total++;
      if (bus.imm !== e || bus.imm_valid !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d instr=%h imm=%h valid=%b want imm=%h valid=1",
                 i, w, bus.imm, bus.imm_valid, e);
      end
`ifdef IMMGEN_FMT_OUT_EN
      total++;
      if (bus.fmt !== expf_q[0]) begin
        bad++;
        $display("FAIL stream_fmt_%0d fmt=%0d want %0d", i, bus.fmt, expf_q[0]);
      end
`endif
      void'(expf_q.pop_front());
      if (i == 13) begin
        rst = 1'b1;
        #1;
        total++;
        if (bus.imm !== 32'h0 || bus.imm_valid !== 1'b0) begin
          bad++;
          $display("FAIL stream_reset imm=%h valid=%b want imm=0 valid=0", bus.imm, bus.imm_valid);
        end
`ifdef IMMGEN_FMT_OUT_EN
        total++;
        if (bus.fmt !== 3'd0) begin
          bad++;
          $display("FAIL stream_reset_fmt fmt=%0d want 0", bus.fmt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
      end
    end
  endtask

  task automatic test_other_opcodes();
    logic [31:0] w;
    logic [31:0] e;
    for (int i = 0; i < 20; i++) begin
      w = $urandom();
      if (i < 4) w = 32'hFFF00092 ^ (32'(i) << 20);
      e = ref_imm(w);
      drive_cycle(1'b1, w);
      total++;
      if (bus.imm !== e || bus.imm_valid !== 1'b1) begin
        bad++;
        $display("FAIL any_%0d instr=%h imm=%h valid=%b want imm=%h valid=1",
                 i, w, bus.imm, bus.imm_valid, e);
      end
    end
    drive_cycle(1'b0, 32'h0);
    total++;
    if (bus.imm_valid !== 1'b0) begin
      bad++;
      $display("FAIL any_valid_drop valid=%b want 0", bus.imm_valid);
    end
  endtask

  initial begin
    bus.en    = 1'b0;
    bus.instr = 32'h0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_other_opcodes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
